// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM bus master: FSM state encoding,
// default bus widths and the active-low pin levels.
package sram_pkg;

    localparam int DEF_ADDR_W = 11;
    localparam int DEF_DATA_W = 16;

    localparam logic CS_ON  = 1'b0;
    localparam logic CS_OFF = 1'b1;
    localparam logic OE_ON  = 1'b0;
    localparam logic OE_OFF = 1'b1;
    localparam logic WE_ON  = 1'b0;
    localparam logic WE_OFF = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_WRITE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_READ  = 3'd4,
        ST_TURN  = 3'd5
    } state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sram_bus_master_if.sv
// Request/response channel between the datapath (master) and the SRAM
// bus controller (slave).
interface sram_bus_master_if
    import sram_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    // A request transfers on a rising edge where req_valid && req_ready are both
    // high; the fields need not be held afterwards. rsp_valid is a single-cycle
    // pulse with no back-pressure, and rsp_rdata holds until the next read ends.
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/sram_bus_driver.sv
// Registered tristate driver for the shared SRAM data bus, plus the capture
// register that samples read data.
module sram_bus_driver #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              drive_d_i,
    input  logic [DATA_W-1:0] wdata_d_i,
    input  logic              capture_i,
    inout  wire  [DATA_W-1:0] data_io,
    output logic [DATA_W-1:0] rdata_o
);

    logic              drive_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drive_q <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            drive_q <= drive_d_i;
            wdata_q <= wdata_d_i;
            if (capture_i) begin
                rdata_q <= data_io;
            end
        end
    end

    assign data_io = drive_q ? wdata_q : {DATA_W{1'bz}};
    assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_bus_master.sv
// Sequences read and write cycles on an asynchronous-style SRAM from a
// valid/ready request channel, with programmable wait states and bus turnaround.
module sram_bus_master
    import sram_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int WR_CYCLES = 2,
    parameter int RD_WAIT   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    sram_bus_master_if.slave  req_if,
    output logic [ADDR_W-1:0] adx,
    output logic              chpSel,
    output logic              OutEn,
    output logic              WrEn,
    inout  wire  [DATA_W-1:0] data,
    output state_t            dbg_state_o
);

    localparam int CNT_MAX = max2(WR_CYCLES, RD_WAIT);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] adx_q, adx_d;
    logic              cs_q, cs_d;
    logic              oe_q, oe_d;
    logic              we_q, we_d;
    logic              ready_q, ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              drive_d;
    logic              capture;
    logic              accept;

    assign accept = (state_q == ST_IDLE) && ready_q && req_if.req_valid;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        adx_d   = adx_q;
        capture = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SETUP;
                    wr_d    = req_if.req_write;
                    wdata_d = req_if.req_wdata;
                    adx_d   = req_if.req_addr;
                end
            end
            ST_SETUP: begin
                if (wr_q) begin
                    state_d = ST_WRITE;
                    cnt_d   = WR_LOAD;
                end else begin
                    state_d = ST_READ;
                    cnt_d   = RD_LOAD;
                end
            end
            ST_WRITE: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLD: state_d = ST_IDLE;
            ST_READ: begin
                if (cnt_q == '0) begin
                    state_d = ST_TURN;
                    capture = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_TURN: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Pin levels are decoded from the next state so the registered pins
        // line up with the state they belong to.
        cs_d        = (state_d inside {ST_SETUP, ST_WRITE, ST_HOLD, ST_READ}) ? CS_ON : CS_OFF;
        oe_d        = ((state_d == ST_READ) || (state_d == ST_SETUP && !wr_d)) ? OE_ON : OE_OFF;
        we_d        = (state_d == ST_WRITE) ? WE_ON : WE_OFF;
        drive_d     = ((state_d == ST_SETUP) && wr_d) || (state_d == ST_WRITE)
                      || (state_d == ST_HOLD);
        ready_d     = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_TURN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            wdata_q     <= '0;
            adx_q       <= '0;
            cs_q        <= CS_OFF;
            oe_q        <= OE_OFF;
            we_q        <= WE_OFF;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            wdata_q     <= wdata_d;
            adx_q       <= adx_d;
            cs_q        <= cs_d;
            oe_q        <= oe_d;
            we_q        <= we_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    sram_bus_driver #(
        .DATA_W (DATA_W)
    ) u_drv (
        .clk       (clk),
        .rst_n     (rst_n),
        .drive_d_i (drive_d),
        .wdata_d_i (wdata_d),
        .capture_i (capture),
        .data_io   (data),
        .rdata_o   (req_if.rsp_rdata)
    );

    assign adx              = adx_q;
    assign chpSel           = cs_q;
    assign OutEn            = oe_q;
    assign WrEn             = we_q;
    assign req_if.req_ready = ready_q;
    assign req_if.rsp_valid = rsp_valid_q;
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_sram_bus_master.sv
// Directed bench for sram_bus_master: one instance with default timing, one with
// WR_CYCLES=1/RD_WAIT=4, each attached to a small behavioural SRAM.
module tb_sram_bus_master;
    import sram_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit sel      = 1'b0;
    bit mon_en   = 1'b0;
    bit sb_en    = 1'b0;
    logic [15:0] exp_q[$];
    logic [15:0] model [int];

    // ---------------- DUT A (defaults) ----------------
    sram_bus_master_if #(.ADDR_W(11), .DATA_W(16)) if_a ();
    logic [10:0] adx_a;
    logic        cs_a, oe_a, we_a;
    wire  [15:0] data_a;
    state_t      dbg_a;
    logic [15:0] mem_a [0:2047];

    sram_bus_master dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_if      (if_a.slave),
        .adx         (adx_a),
        .chpSel      (cs_a),
        .OutEn       (oe_a),
        .WrEn        (we_a),
        .data        (data_a),
        .dbg_state_o (dbg_a)
    );

    assign data_a = (!cs_a && !oe_a && we_a) ? mem_a[adx_a] : 16'bz;
    always @(posedge clk) if (!cs_a && !we_a) mem_a[adx_a] <= data_a;

    // ---------------- DUT B (short write, long read) ----------------
    sram_bus_master_if #(.ADDR_W(11), .DATA_W(16)) if_b ();
    logic [10:0] adx_b;
    logic        cs_b, oe_b, we_b;
    wire  [15:0] data_b;
    state_t      dbg_b;
    logic [15:0] mem_b [0:2047];

    sram_bus_master #(.WR_CYCLES(1), .RD_WAIT(4)) dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_if      (if_b.slave),
        .adx         (adx_b),
        .chpSel      (cs_b),
        .OutEn       (oe_b),
        .WrEn        (we_b),
        .data        (data_b),
        .dbg_state_o (dbg_b)
    );

    assign data_b = (!cs_b && !oe_b && we_b) ? mem_b[adx_b] : 16'bz;
    always @(posedge clk) if (!cs_b && !we_b) mem_b[adx_b] <= data_b;

    // Selected-DUT views used by the driver tasks
    logic        drv_a, drv_b;
    assign drv_a = dut_a.u_drv.drive_q;
    assign drv_b = dut_b.u_drv.drive_q;

    logic        m_cs, m_oe, m_we, m_drive, m_ready, m_rsp_valid;
    logic [10:0] m_adx;
    logic [15:0] m_data, m_rsp_rdata;
    state_t      m_state;
    assign m_cs        = sel ? cs_b : cs_a;
    assign m_oe        = sel ? oe_b : oe_a;
    assign m_we        = sel ? we_b : we_a;
    assign m_drive     = sel ? drv_b : drv_a;
    assign m_adx       = sel ? adx_b : adx_a;
    assign m_data      = sel ? data_b : data_a;
    assign m_ready     = sel ? if_b.req_ready : if_a.req_ready;
    assign m_rsp_valid = sel ? if_b.rsp_valid : if_a.rsp_valid;
    assign m_rsp_rdata = sel ? if_b.rsp_rdata : if_a.rsp_rdata;
    assign m_state     = sel ? dbg_b : dbg_a;

    // ---------------- checker ----------------
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- bus invariant monitors ----------------
    logic        prev_oe_a = 1'b1, prev_cs_a = 1'b1, prev_oe_b = 1'b1, prev_cs_b = 1'b1;
    logic [10:0] prev_adx_a = '0, prev_adx_b = '0;

    always @(negedge clk) begin
        if (mon_en) begin
            check_eq("a_we_oe_overlap", 32'(!we_a && !oe_a), 0);
            check_eq("a_drive_near_oe", 32'(drv_a && (!oe_a || !prev_oe_a)), 0);
            check_eq("a_we_without_cs", 32'(!we_a && cs_a), 0);
            if (!cs_a && !prev_cs_a) check_eq("a_adx_stable", 32'(adx_a), 32'(prev_adx_a));
            check_eq("b_we_oe_overlap", 32'(!we_b && !oe_b), 0);
            check_eq("b_drive_near_oe", 32'(drv_b && (!oe_b || !prev_oe_b)), 0);
            check_eq("b_we_without_cs", 32'(!we_b && cs_b), 0);
            if (!cs_b && !prev_cs_b) check_eq("b_adx_stable", 32'(adx_b), 32'(prev_adx_b));
        end
        prev_oe_a  <= oe_a;
        prev_cs_a  <= cs_a;
        prev_adx_a <= adx_a;
        prev_oe_b  <= oe_b;
        prev_cs_b  <= cs_b;
        prev_adx_b <= adx_b;
    end

    // ---------------- scoreboard for back-to-back traffic on A ----------------
    always @(negedge clk) begin
        if (sb_en && if_a.rsp_valid) begin
            if (exp_q.size() == 0) check_eq("sb_unexpected_rsp", 32'(exp_q.size()), 1);
            else                   check_eq("sb_rdata", 32'(if_a.rsp_rdata), 32'(exp_q.pop_front()));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_req(input logic v, input logic wr, input logic [10:0] addr,
                           input logic [15:0] wd);
        if (sel) begin
            if_b.req_valid = v; if_b.req_write = wr; if_b.req_addr = addr; if_b.req_wdata = wd;
        end else begin
            if_a.req_valid = v; if_a.req_write = wr; if_a.req_addr = addr; if_a.req_wdata = wd;
        end
    endtask

    // Returns at the negedge of cycle 1 after the accept edge, inputs scrambled.
    task automatic present_req(input logic wr, input logic [10:0] addr, input logic [15:0] wd,
                               input string tag);
        int waitc = 0;
        @(negedge clk);
        set_req(1'b1, wr, addr, wd);
        while (!m_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        check_eq({tag, "_accept"}, 32'(waitc < 50), 1);
        @(posedge clk);
        @(negedge clk);
        set_req(1'b0, ~wr, ~addr, ~wd);
    endtask

    task automatic run_op(input logic wr, input logic [10:0] addr, input logic [15:0] wd,
                          input int wr_cyc, input int rd_wait, input string tag);
        int we_low = 0, rv_cnt = 0, rv_at = 0, drv_cnt = 0, drv_ok = 0, rdy_at = 0, adx_bad = 0;
        logic [15:0] got_rd = '0;
        logic [15:0] mem_now;
        present_req(wr, addr, wd, tag);
        for (int c = 1; c <= 10; c++) begin
            if (!m_we) we_low++;
            if (m_rsp_valid) begin rv_cnt++; rv_at = c; got_rd = m_rsp_rdata; end
            if (m_drive) begin drv_cnt++; if (m_data == wd) drv_ok++; end
            if (m_ready && rdy_at == 0) rdy_at = c;
            if (!m_cs && m_adx != addr) adx_bad++;
            if (c < 10) @(negedge clk);
        end
        check_eq({tag, "_adx"}, 32'(adx_bad), 0);
        check_eq({tag, "_ready_at"}, 32'(rdy_at), 32'(wr ? wr_cyc + 3 : rd_wait + 3));
        if (wr) begin
            mem_now = sel ? mem_b[addr] : mem_a[addr];
            check_eq({tag, "_we_low"}, 32'(we_low), 32'(wr_cyc));
            check_eq({tag, "_drive_cycles"}, 32'(drv_cnt), 32'(wr_cyc + 2));
            check_eq({tag, "_drive_value"}, 32'(drv_ok), 32'(wr_cyc + 2));
            check_eq({tag, "_no_rsp"}, 32'(rv_cnt), 0);
            check_eq({tag, "_mem"}, 32'(mem_now), 32'(wd));
        end else begin
            check_eq({tag, "_we_low"}, 32'(we_low), 0);
            check_eq({tag, "_bus_z"}, 32'(drv_cnt), 0);
            check_eq({tag, "_rsp_count"}, 32'(rv_cnt), 1);
            check_eq({tag, "_rsp_at"}, 32'(rv_at), 32'(rd_wait + 2));
            check_eq({tag, "_rdata"}, 32'(got_rd), 32'(wd));
            check_eq({tag, "_rdata_hold"}, 32'(m_rsp_rdata), 32'(wd));
        end
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_cs"}, 32'(m_cs), 1);
        check_eq({tag, "_oe"}, 32'(m_oe), 1);
        check_eq({tag, "_we"}, 32'(m_we), 1);
        check_eq({tag, "_bus_z"}, 32'(m_drive), 0);
        check_eq({tag, "_ready"}, 32'(m_ready), 0);
        check_eq({tag, "_rsp_valid"}, 32'(m_rsp_valid), 0);
        check_eq({tag, "_rdata"}, 32'(m_rsp_rdata), 0);
        check_eq({tag, "_adx"}, 32'(m_adx), 0);
        check_eq({tag, "_state"}, 32'(m_state), 32'(ST_IDLE));
    endtask

    logic        op_wr   [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [10:0] op_addr [9] = '{11'd0, 11'd0, 11'd1, 11'd1, 11'h7FF, 11'h7FF, 11'd0, 11'd0, 11'd1};
    logic [15:0] op_data [9] = '{16'h1111, 16'h0, 16'h2222, 16'h0, 16'h3333, 16'h0,
                                 16'h4444, 16'h0, 16'h0};

    task automatic run_b2b();
        int waitc;
        sb_en = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            set_req(1'b1, op_wr[i], op_addr[i], op_data[i]);
            waitc = 0;
            while (!m_ready && waitc < 50) begin
                @(negedge clk);
                waitc++;
            end
            check_eq("b2b_accept", 32'(waitc < 50), 1);
            check_eq("b2b_idle_cs", 32'(m_cs), 1);
            if (op_wr[i]) model[int'(op_addr[i])] = op_data[i];
            else          exp_q.push_back(model[int'(op_addr[i])]);
            @(posedge clk);
            @(negedge clk);
        end
        set_req(1'b0, 1'b0, 11'd0, 16'd0);
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
        check_eq("b2b_drained", 32'(exp_q.size()), 0);
        sb_en = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int rv_seen;
        set_req(1'b0, 1'b0, 11'd0, 16'd0);
        sel = 1'b1;
        set_req(1'b0, 1'b0, 11'd0, 16'd0);
        sel = 1'b0;

        // Power-up reset
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        mon_en = 1'b1;
        check_reset("por_a");
        sel = 1'b1;
        check_reset("por_b");
        sel = 1'b0;
        rst_n = 1'b1;
        check_eq("por_ready_before_edge", 32'(m_ready), 0);
        @(negedge clk);
        check_eq("por_ready_after_edge", 32'(m_ready), 1);

        // Reset held for 3 edges in the middle of a write
        present_req(1'b1, 11'h7FF, 16'h5A5A, "rstw");
        @(negedge clk);
        check_eq("rstw_in_write", 32'(m_we), 0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("rstw");
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rstw_ready_back", 32'(m_ready), 1);

        // Single write / read-back at the top address
        run_op(1'b1, 11'h7FF, 16'hA5C3, 2, 2, "wr7ff");
        run_op(1'b0, 11'h7FF, 16'hA5C3, 2, 2, "rd7ff");

        // Alternating traffic with req_valid held high
        run_b2b();

        // Short-write / long-read instance
        sel = 1'b1;
        run_op(1'b1, 11'h005, 16'hBEEF, 1, 4, "b_wr5");
        run_op(1'b0, 11'h005, 16'hBEEF, 1, 4, "b_rd5");
        run_op(1'b1, 11'h7FF, 16'h0F0F, 1, 4, "b_wr7ff");
        run_op(1'b0, 11'h7FF, 16'h0F0F, 1, 4, "b_rd7ff");
        sel = 1'b0;

        // Reset pulse during a read cycle, then re-read the same word
        present_req(1'b0, 11'd1, 16'd0, "rstr");
        @(negedge clk);
        check_eq("rstr_in_read", 32'(m_oe), 0);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("rstr_bus_z", 32'(m_drive), 0);
        check_eq("rstr_oe_off", 32'(m_oe), 1);
        check_eq("rstr_cs_off", 32'(m_cs), 1);
        rst_n = 1'b1;
        rv_seen = 0;
        for (int c = 0; c < 8; c++) begin
            if (m_rsp_valid) rv_seen++;
            @(negedge clk);
        end
        check_eq("rstr_no_rsp", 32'(rv_seen), 0);
        run_op(1'b0, 11'd1, 16'h2222, 2, 2, "rstr_reread");

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
